alu_vec_sequencer: RTL
======================

Name: alu_vec_sequencer

Overview:
- Parametrised successor to the fixed-schedule ALU stimulus driver.
- Plays a loadable table of directed ALU vectors (control, A, B), then a seeded pseudo-random phase.
- Folds every DUT result into a MISR signature and flags a mismatch against an expected signature.
- Sits in the Verilator harness between the clock source and the ALU under test; one vector in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; legal 8..32.
- CTRL_W, 4, ALU control field width.
- NUM_OPS, 15, random control values are 0..NUM_OPS-1; legal 1..2^CTRL_W.
- DIR_DEPTH, 16, directed table entries (power of 2).
- RAND_COUNT, 64, random vectors per run; 0 skips the random phase.
- TIMEOUT, 15, max cycles from accepted vector to res_valid.
- LFSR_SEED, 32'h0000_0001, random-phase seed; 0 is illegal and is replaced by 1.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous active-high reset.
- tbl_we  in  1  directed table write; honoured only in IDLE.
- tbl_addr  in  log2(DIR_DEPTH)  write address.
- tbl_data  in  CTRL_W+2*WIDTH  {ctrl, A, B}.
- start  in  1  begin run; honoured only in IDLE.
- dir_len  in  log2(DIR_DEPTH)+1  directed entries to play (0..DIR_DEPTH); sampled at start.
- exp_sig  in  WIDTH  expected final signature; sampled at start.
- alu_ctrl  out  CTRL_W  vector control.
- op_a, op_b  out  WIDTH  vector operands.
- vec_valid  out  1  vector presented.
- vec_ready  in  1  DUT accepts the vector.
- res  in  WIDTH  ALU result.
- res_zero  in  1  ALU Zero flag.
- res_valid  in  1  result strobe.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- pass  out  1  valid when done: signature==exp_sig and no timeout.
- err_timeout  out  1  sticky timeout flag.
- signature  out  WIDTH  current MISR value.
- vec_count  out  16  vectors completed this run.

Behaviour:
- Reset (synchronous, active-high): the following all go to 0.
  - State and outputs: state=IDLE, vec_valid, busy, done, pass, err_timeout, signature, vec_count, alu_ctrl, op_a, op_b.
  - LFSR = LFSR_SEED.
  - Table contents are not reset.
  - Reset mid-run aborts immediately; a late res_valid after reset is ignored.
- States:
  - IDLE --start--> DIR (or GEN if dir_len=0).
  - DIR: present table[idx]; vec_valid=1.
  - ISSUE handshake: transfer when vec_valid & vec_ready in the same cycle; the next cycle enters WAIT with vec_valid=0. Outputs are held stable while vec_valid=1 and ready=0.
  - WAIT: the timeout counter counts from 1.
    - On res_valid: signature <= {sig[WIDTH-2:0], ^(sig & POLY)} ^ res ^ {{WIDTH-1{0}}, res_zero}; vec_count++.
    - Next state is DIR if more directed entries remain, else GEN if RAND_COUNT>0, else FIN.
  - GEN: three cycles, LFSR advancing once per cycle: step1 → op_a=lfsr[WIDTH-1:0]; step2 → op_b; step3 → alu_ctrl=lfsr[7:0] % NUM_OPS. Then present with vec_valid=1 and take the same handshake and WAIT.
  - FIN: one cycle; pass <= (signature==exp_sig_latched) & ~err_timeout; done=1; busy=0; go to IDLE.
- Timeout: if WAIT reaches TIMEOUT cycles without res_valid → err_timeout=1, go to FIN (pass=0).
- res_valid outside WAIT is ignored.
- busy=1 from the cycle after start until FIN.
- start while busy is ignored.
- A new start clears done, pass, err_timeout, signature, vec_count; the LFSR reloads LFSR_SEED.
- LFSR: 32-bit Galois, right shift: next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
- POLY = WIDTH low bits of 32'h8020_0003.
- vec_count saturates at 16'hFFFF.
- Simultaneous tbl_we and start in IDLE: the write commits first and is visible to the run.

Decomposition:
- Package alu_vec_pkg holds:
  - State enum: IDLE, DIR, GEN, ISSUE, WAIT, FIN.
  - LFSR_TAPS=32'h8020_0003.
  - Function misr_next(sig, res, zero, width).
- One sub-module: alu_vec_lfsr (32-bit Galois, load/step), reused by other harness stimulus blocks.

Test Plan:
- Directed-only run: load 2 entries {0,2,2},{1,2,2}; dir_len=2; RAND_COUNT=0; DUT returns res=4 then 2, zero=0. Required: vec_count=2, signature=32'h0000_000A, pass=1 when exp_sig=32'h0000_000A.
- Random-phase values: dir_len=0, seed 1, WIDTH=32. Required first vector: op_a=32'h8020_0003, op_b=32'hC030_0002, alu_ctrl=1.
- Backpressure: vec_ready low for 5 cycles. Required: op_a, op_b, alu_ctrl stable with vec_valid=1 throughout; exactly one transfer.
- Timeout: no res_valid for 15 cycles after transfer. Required: err_timeout=1, done=1, pass=0, vec_count=0.
- Reset mid-WAIT followed by res_valid. Required: all outputs 0, state IDLE, signature stays 0.
- Restart: second start with identical table and seed. Required: identical signature; start pulsed while busy has no effect.

Source files
------------

// File: rtl/alu_vec_pkg.sv
// Shared types and helpers for the ALU vector sequencer and related harness stimulus blocks.
package alu_vec_pkg;

  typedef enum logic [2:0] {IDLE, DIR, GEN, ISSUE, WAIT, FIN} state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One MISR fold: shift left with feedback parity, then absorb result and Zero flag.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] res,
                                            input logic        zero,
                                            input int          width);
    logic [31:0] mask;
    logic [31:0] poly;
    logic [31:0] sh;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    poly = LFSR_TAPS & mask;
    sh   = {sig[30:0], ^(sig & poly)};
    return (sh ^ res ^ {31'd0, zero}) & mask;
  endfunction

endpackage

// File: rtl/alu_vec_lfsr.sv
// 32-bit right-shifting Galois LFSR with seed load and step; o_next is the value the next step commits.
module alu_vec_lfsr
  import alu_vec_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_seed,
  input  logic        i_load,
  input  logic        i_step,
  output logic [31:0] o_next
);

  logic [31:0] r_state;
  logic [31:0] w_seed;

  // An all-zero state would lock the register up.
  assign w_seed = (i_seed == 32'd0) ? 32'd1 : i_seed;
  assign o_next = (r_state >> 1) ^ (r_state[0] ? LFSR_TAPS : 32'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_state <= w_seed;
    else if (i_load) r_state <= w_seed;
    else if (i_step) r_state <= o_next;
  end

endmodule

// File: rtl/alu_vec_sequencer.sv
// Plays a directed ALU vector table then a seeded random phase, folding results into a MISR.
module alu_vec_sequencer
  import alu_vec_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          CTRL_W     = 4,
  parameter int          NUM_OPS    = 15,
  parameter int          DIR_DEPTH  = 16,
  parameter int          RAND_COUNT = 64,
  parameter int          TIMEOUT    = 15,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
)(
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic                           tbl_we,
  input  logic [$clog2(DIR_DEPTH)-1:0]   tbl_addr,
  input  logic [CTRL_W+2*WIDTH-1:0]      tbl_data,
  input  logic                           start,
  input  logic [$clog2(DIR_DEPTH):0]     dir_len,
  input  logic [WIDTH-1:0]               exp_sig,
  output logic [CTRL_W-1:0]              alu_ctrl,
  output logic [WIDTH-1:0]               op_a,
  output logic [WIDTH-1:0]               op_b,
  output logic                           vec_valid,
  input  logic                           vec_ready,
  input  logic [WIDTH-1:0]               res,
  input  logic                           res_zero,
  input  logic                           res_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           err_timeout,
  output logic [WIDTH-1:0]               signature,
  output logic [15:0]                    vec_count
);

  localparam int AW   = $clog2(DIR_DEPTH);
  localparam int TD_W = CTRL_W + 2*WIDTH;
  localparam int TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int RCW  = (RAND_COUNT < 2) ? 1 : $clog2(RAND_COUNT + 1);
  localparam bit HAS_RAND = (RAND_COUNT > 0);

  state_e            r_state, w_state_nxt;
  logic [TD_W-1:0]   r_tbl [DIR_DEPTH];
  logic [AW:0]       r_dir_len, r_dir_idx, w_len_clamp;
  logic [RCW-1:0]    r_rand_idx;
  logic [1:0]        r_gen_step;
  logic [TW-1:0]     r_tmo;
  logic [WIDTH-1:0]  r_exp, r_sig, w_sig_nxt;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [CTRL_W-1:0] r_ctrl;
  logic [15:0]       r_cnt;
  logic              r_done, r_pass, r_err;
  logic [31:0]       w_lfsr_nxt;
  logic [8:0]        w_rand_op;
  logic              w_start, w_dir_more, w_rand_more, w_tmo_hit, w_lfsr_step;

  assign w_start     = (r_state == IDLE) && start;
  assign w_len_clamp = (dir_len > (AW+1)'(DIR_DEPTH)) ? (AW+1)'(DIR_DEPTH) : dir_len;
  assign w_dir_more  = (r_dir_idx < r_dir_len);
  assign w_rand_more = (r_rand_idx < RCW'(RAND_COUNT));
  assign w_tmo_hit   = (r_state == WAIT) && !res_valid && (r_tmo == TW'(TIMEOUT));
  assign w_sig_nxt   = WIDTH'(misr_next(32'(r_sig), 32'(res), res_zero, WIDTH));
  assign w_rand_op   = {1'b0, w_lfsr_nxt[7:0]} % 9'(NUM_OPS);
  assign w_lfsr_step = (r_state == GEN);

  alu_vec_lfsr u_lfsr (
    .i_clk  (sys_clk),
    .i_rst  (sys_rst),
    .i_seed (LFSR_SEED),
    .i_load (w_start),
    .i_step (w_lfsr_step),
    .o_next (w_lfsr_nxt)
  );

  // Table has no reset; writes land only while idle, so a write alongside start is seen by the run.
  always_ff @(posedge sys_clk) begin
    if (tbl_we && r_state == IDLE) r_tbl[tbl_addr] <= tbl_data;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start) begin
               if (w_len_clamp != '0) w_state_nxt = DIR;
               else if (HAS_RAND)     w_state_nxt = GEN;
               else                   w_state_nxt = FIN;
             end
      DIR:   w_state_nxt = ISSUE;
      GEN:   if (r_gen_step == 2'd2) w_state_nxt = ISSUE;
      ISSUE: if (vec_ready) w_state_nxt = WAIT;
      WAIT:  if (res_valid) begin
               if (w_dir_more)       w_state_nxt = DIR;
               else if (w_rand_more) w_state_nxt = GEN;
               else                  w_state_nxt = FIN;
             end else if (w_tmo_hit) w_state_nxt = FIN;
      FIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vec_valid = (r_state == ISSUE);
    busy      = (r_state inside {DIR, GEN, ISSUE, WAIT});
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_dir_len  <= '0;
      r_dir_idx  <= '0;
      r_rand_idx <= '0;
      r_gen_step <= '0;
      r_tmo      <= '0;
      r_exp      <= '0;
      r_sig      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_ctrl     <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_dir_len  <= w_len_clamp;
          r_dir_idx  <= '0;
          r_rand_idx <= '0;
          r_gen_step <= '0;
          r_exp      <= exp_sig;
          r_sig      <= '0;
          r_cnt      <= '0;
          r_done     <= 1'b0;
          r_pass     <= 1'b0;
          r_err      <= 1'b0;
        end
        DIR: begin
          {r_ctrl, r_a, r_b} <= r_tbl[r_dir_idx[AW-1:0]];
          r_dir_idx          <= r_dir_idx + 1'b1;
        end
        // Each step consumes the freshly advanced LFSR word.
        GEN: begin
          case (r_gen_step)
            2'd0:    r_a <= w_lfsr_nxt[WIDTH-1:0];
            2'd1:    r_b <= w_lfsr_nxt[WIDTH-1:0];
            default: begin
              r_ctrl     <= CTRL_W'(w_rand_op);
              r_rand_idx <= r_rand_idx + 1'b1;
            end
          endcase
          r_gen_step <= (r_gen_step == 2'd2) ? 2'd0 : r_gen_step + 2'd1;
        end
        ISSUE: if (vec_ready) r_tmo <= TW'(1);
        WAIT: begin
          if (res_valid) begin
            r_sig <= w_sig_nxt;
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
          end else if (w_tmo_hit) begin
            r_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        FIN: begin
          r_done <= 1'b1;
          r_pass <= (r_sig == r_exp) && !r_err;
        end
        default: ;
      endcase
    end
  end

  assign alu_ctrl    = r_ctrl;
  assign op_a        = r_a;
  assign op_b        = r_b;
  assign done        = r_done;
  assign pass        = r_pass;
  assign err_timeout = r_err;
  assign signature   = r_sig;
  assign vec_count   = r_cnt;

endmodule
